// File: rtl/io_port_arbiter_if.sv
// Request/response bundle between the bus masters, the I/O port arbiter and
// the physical pins. Per-requester fields are packed side by side, requester 0 in the LSBs.
interface io_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [2*NUM_REQ-1:0]      op;
  logic [DATA_W*NUM_REQ-1:0] wdata;
  logic [DATA_W*NUM_REQ-1:0] wmask;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic [DATA_W-1:0]         input_pins;
  logic [DATA_W-1:0]         output_pins;

  modport master (
    output req, op, wdata, wmask, input_pins,
    input  ack, rdata, output_pins
  );

  modport slave (
    input  req, op, wdata, wmask, input_pins,
    output ack, rdata, output_pins
  );
endinterface

// File: rtl/io_port_arbiter.sv
// Round-robin arbiter that owns the top-level output pin register and serves
// read / masked write / bit-set / bit-clear requests from NUM_REQ masters.
// Optional macro IO_ARB_INPUT_SYNC_EN adds a 2-flop synchronizer on input_pins.
module io_port_arbiter #(
  parameter int                NUM_REQ   = 2,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              n_rst,
  io_port_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SET   = 2'd2,
    OP_CLR   = 2'd3
  } op_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  op_t                op_q, op_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  wmask_q, wmask_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic [1:0]         req_op    [NUM_REQ];
  logic [DATA_W-1:0]  req_wdata [NUM_REQ];
  logic [DATA_W-1:0]  req_wmask [NUM_REQ];

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [DATA_W-1:0]  pin_sample;
  logic [DATA_W-1:0]  new_out;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_op[gi]    = bus.op[2*gi +: 2];
    assign req_wdata[gi] = bus.wdata[DATA_W*gi +: DATA_W];
    assign req_wmask[gi] = bus.wmask[DATA_W*gi +: DATA_W];
  end

`ifdef IO_ARB_INPUT_SYNC_EN
  logic [DATA_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.input_pins;
      sync2_q <= sync1_q;
    end
  end

  assign pin_sample = sync2_q;
`else
  assign pin_sample = bus.input_pins;
`endif

  // Search starts one past the last grant so the previous winner goes last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_q) + i) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    new_out = out_q;
    case (op_q)
      OP_WRITE: new_out = (out_q & ~wmask_q) | (wdata_q & wmask_q);
      OP_SET:   new_out = out_q | wdata_q;
      OP_CLR:   new_out = out_q & ~wdata_q;
      default:  new_out = out_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    out_d   = out_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          op_d    = op_t'(req_op[win_idx]);
          wdata_d = req_wdata[win_idx];
          wmask_d = req_wmask[win_idx];
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (op_q == OP_READ) begin
          rdata_d = pin_sample;
        end else begin
          out_d   = new_out;
          rdata_d = new_out;
        end
        // ack is registered so it lands in the DONE cycle alongside the new pins.
        ack_d[grant_q] = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        rr_d    = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= IDX_W'(NUM_REQ - 1);
      op_q    <= OP_READ;
      wdata_q <= '0;
      wmask_q <= '0;
      out_q   <= RESET_VAL;
      rdata_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      out_q   <= out_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.output_pins = out_q;

endmodule
